// File: rtl/rx_link_sync_ctrl.sv
// Comma-based link synchronisation controller behind the 8b/10b receive decoder.
// Acquires/loses sync, requests bit-slips, forwards clean data and counts errored symbols.
module rx_link_sync_ctrl #(
  parameter int unsigned COMMA_CNT    = 3,
  parameter int unsigned GOOD_CNT     = 4,
  parameter int unsigned BAD_MAX      = 4,
  parameter int unsigned SLIP_TIMEOUT = 16,
  parameter int unsigned ERRCNT_W     = 16,
  parameter bit          STRIP_COMMA  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [8:0]          sym_i,
  input  logic                sym_valid_i,
  input  logic                code_err_i,
  input  logic                disp_err_i,
  input  logic                clr_cnt_i,
  output logic [8:0]          data_o,
  output logic                data_valid_o,
  output logic                sync_o,
  output logic                slip_o,
  output logic                comma_o,
  output logic [1:0]          state_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  localparam int unsigned CW = $clog2(COMMA_CNT + 1);
  localparam int unsigned GW = $clog2(GOOD_CNT + 1);
  localparam int unsigned BW = $clog2(BAD_MAX + 1);
  localparam int unsigned TW = $clog2(SLIP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StLoss  = 2'd0,
    StAcq   = 2'd1,
    StSync  = 2'd2,
    StCheck = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       ccnt_q, ccnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [8:0]          data_q, data_d;
  logic                dv_q, dv_d;
  logic                sync_q, sync_d;
  logic                slip_q, slip_d;
  logic                comma_q, comma_d;
  logic [ERRCNT_W-1:0] err_q, err_d;

  logic bad, is_comma, in_sync;

  assign bad      = code_err_i | disp_err_i;
  assign is_comma = !bad && (sym_i == 9'h1BC);
  assign in_sync  = (state_q == StSync) || (state_q == StCheck);

  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    gcnt_d  = gcnt_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    slip_d  = 1'b0;
    comma_d = 1'b0;
    err_d   = err_q;

    if (sym_valid_i) begin
      comma_d = is_comma;
      if (bad && (err_q != {ERRCNT_W{1'b1}})) err_d = err_q + ERRCNT_W'(1);
      if (in_sync && !bad && !(is_comma && STRIP_COMMA)) begin
        dv_d   = 1'b1;
        data_d = sym_i;
      end

      unique case (state_q)
        StLoss: begin
          if (is_comma) begin
            tcnt_d = '0;
            if (COMMA_CNT <= 1) begin
              state_d = StSync;
              ccnt_d  = '0;
            end else begin
              state_d = StAcq;
              ccnt_d  = CW'(1);
            end
          end else if (tcnt_q == TW'(SLIP_TIMEOUT - 1)) begin
            slip_d = 1'b1;
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        StAcq: begin
          if (bad) begin
            state_d = StLoss;
            ccnt_d  = '0;
            tcnt_d  = '0;
          end else if (is_comma) begin
            if (ccnt_q + CW'(1) == CW'(COMMA_CNT)) begin
              state_d = StSync;
              ccnt_d  = '0;
            end else begin
              ccnt_d = ccnt_q + CW'(1);
            end
          end
        end
        StSync: begin
          if (bad) begin
            state_d = StCheck;
            bcnt_d  = BW'(1);
            gcnt_d  = '0;
          end
        end
        StCheck: begin
          if (bad) begin
            gcnt_d = '0;
            if (bcnt_q + BW'(1) == BW'(BAD_MAX)) begin
              state_d = StLoss;
              bcnt_d  = '0;
              ccnt_d  = '0;
              tcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else if (gcnt_q + GW'(1) == GW'(GOOD_CNT)) begin
            // A run of clean symbols forgives one bad credit.
            gcnt_d = '0;
            bcnt_d = bcnt_q - BW'(1);
            if (bcnt_q == BW'(1)) state_d = StSync;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        default: state_d = StLoss;
      endcase
    end

    if (clr_cnt_i) err_d = '0;
    sync_d = (state_d == StSync) || (state_d == StCheck);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StLoss;
      ccnt_q  <= '0;
      gcnt_q  <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      sync_q  <= 1'b0;
      slip_q  <= 1'b0;
      comma_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      gcnt_q  <= gcnt_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      sync_q  <= sync_d;
      slip_q  <= slip_d;
      comma_q <= comma_d;
      err_q   <= err_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign sync_o       = sync_q;
  assign slip_o       = slip_q;
  assign comma_o      = comma_q;
  assign state_o      = state_q;
  assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_rx_link_sync_ctrl.sv
// Scoreboard bench for rx_link_sync_ctrl: each strobed symbol queues its expected
// response; a monitor pops and compares it one clock after the strobe.
module tb_rx_link_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] sym = '0;
  logic       sv = 1'b0, ce = 1'b0, de = 1'b0, clr = 1'b0;
  logic [8:0] data_o;
  logic       data_valid_o, sync_o, slip_o, comma_o;
  logic [1:0] state_o;
  logic [3:0] err_cnt_o;

  always #5 clk = ~clk;

  rx_link_sync_ctrl #(.ERRCNT_W(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sym_i        (sym),
    .sym_valid_i  (sv),
    .code_err_i   (ce),
    .disp_err_i   (de),
    .clr_cnt_i    (clr),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sync_o       (sync_o),
    .slip_o       (slip_o),
    .comma_o      (comma_o),
    .state_o      (state_o),
    .err_cnt_o    (err_cnt_o)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       sync;
    logic       dv;
    logic [8:0] data;
    logic       slip;
    logic       comma;
    logic [3:0] err;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] e_err = '0;
  logic [8:0] e_data = '0;

  function automatic exp_t got_now();
    return '{state_o, sync_o, data_valid_o, data_o, slip_o, comma_o, err_cnt_o};
  endfunction

  task automatic compare(input string name, input exp_t g, input exp_t e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s (got/exp) st=%0d/%0d sync=%b/%b dv=%b/%b data=%h/%h slip=%b/%b comma=%b/%b err=%0d/%0d",
               name, g.st, e.st, g.sync, e.sync, g.dv, e.dv, g.data, e.data,
               g.slip, e.slip, g.comma, e.comma, g.err, e.err);
    end
  endtask

  // Monitor: one response per symbol accepted at the previous edge.
  initial begin
    logic v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = sv && !rst;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_underflow got st=%0d required queued entry", state_o);
        end else begin
          e = exp_q.pop_front();
          compare($sformatf("vec%0d", vectors), got_now(), e);
        end
      end else if (slip_o || data_valid_o || comma_o) begin
        miscompares++;
        $display("FAIL idle_pulse got slip=%b dv=%b comma=%b required 000",
                 slip_o, data_valid_o, comma_o);
      end
    end
  end

  task automatic send(input logic [8:0] s, input logic c_e, input logic d_e, input logic cl,
                      input logic [1:0] st, input logic dv, input logic sl, input logic cm);
    if (cl) e_err = '0;
    else if (c_e || d_e) e_err = (e_err == 4'hF) ? 4'hF : e_err + 4'd1;
    if (dv) e_data = s;
    exp_q.push_back('{st, st[1], dv, e_data, sl, cm, e_err});
    @(negedge clk);
    sym = s; ce = c_e; de = d_e; clr = cl; sv = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sv = 1'b0; ce = 1'b0; de = 1'b0; clr = 1'b0;
    end
  endtask

  task automatic check_zero(input string name);
    e_err = '0;
    e_data = '0;
    compare(name, got_now(), '0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Acquire: three commas
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);
    send(9'h1BC, 0, 0, 0, 2'd2, 0, 0, 1);
    // Data forwarding in SYNC, comma stripped, other K forwarded
    send(9'h04A, 0, 0, 0, 2'd2, 1, 0, 0);
    send(9'h1BC, 0, 0, 0, 2'd2, 0, 0, 1);
    send(9'h17C, 0, 0, 0, 2'd2, 1, 0, 0);
    idle(2);

    // CHECK with one credit forgiven by 4 clean symbols
    send(9'h055, 1, 0, 0, 2'd3, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(9'h0A0 + 9'(i), 0, 0, 0, (i == 3) ? 2'd2 : 2'd3, 1, 0, 0);
    // bcnt=2, three clean, one bad: gcnt restarts, bcnt=3
    send(9'h011, 1, 0, 0, 2'd3, 0, 0, 0);
    send(9'h011, 0, 1, 0, 2'd3, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(9'h020 + 9'(i), 0, 0, 0, 2'd3, 1, 0, 0);
    send(9'h011, 1, 1, 0, 2'd3, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(9'h030 + 9'(i), 0, 0, 0, 2'd3, 1, 0, 0);
    // bcnt 2 -> 3 -> 4 = BAD_MAX drops to LOSS
    send(9'h011, 1, 0, 0, 2'd3, 0, 0, 0);
    send(9'h011, 1, 0, 0, 2'd0, 0, 0, 0);
    idle(1);

    // Slip timeout in LOSS: two pulses, then comma at the 10th symbol
    for (int i = 0; i < 16; i++) send(9'h000, 0, 0, 0, 2'd0, 0, (i == 15), 0);
    for (int i = 0; i < 16; i++) send(9'h000, 0, 0, 0, 2'd0, 0, (i == 15), 0);
    for (int i = 0; i < 9; i++) send(9'h000, 0, 0, 0, 2'd0, 0, 0, 0);
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);

    // Reset with a would-be third comma strobed: aborted, all outputs 0
    @(negedge clk);
    rst = 1'b1; sym = 9'h1BC; sv = 1'b1; ce = 1'b0; de = 1'b0;
    @(negedge clk);
    rst = 1'b0; sv = 1'b0;
    check_zero("mid_reset");
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);
    send(9'h1BC, 0, 0, 0, 2'd2, 0, 0, 1);

    // Four errored symbols in SYNC: CHECK after first, LOSS after fourth, err=4
    send(9'h04A, 1, 0, 0, 2'd3, 0, 0, 0);
    send(9'h04A, 0, 1, 0, 2'd3, 0, 0, 0);
    send(9'h04A, 1, 1, 0, 2'd3, 0, 0, 0);
    send(9'h1BC, 1, 0, 0, 2'd0, 0, 0, 0);
    idle(1);

    // Saturation at 15; errored symbols still advance the slip timer
    for (int i = 0; i < 20; i++) send(9'h000, 1, 0, 0, 2'd0, 0, (i == 15), 0);
    send(9'h000, 1, 0, 1, 2'd0, 0, 0, 0);
    send(9'h1BC, 0, 0, 0, 2'd1, 0, 0, 1);
    idle(3);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
